// File: rtl/argmax_pkg.sv
// Shared definitions for the streaming argmax block: FSM state encoding and
// the ceiling-log2 helper used to validate the position width.
package argmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/argmax_value_cmp.sv
// Magnitude comparator for one sample against the running maximum; the
// signedness of the compare is fixed at elaboration by SIGNED_MODE.
module argmax_value_cmp
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SIGNED_MODE = 1
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  gt,
  output logic                  eq
);

  generate
    if (SIGNED_MODE != 0) begin : g_signed
      assign gt = ($signed(a) > $signed(b));
    end else begin : g_unsigned
      assign gt = (a > b);
    end
  endgenerate

  assign eq = (a == b);

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over NUM_VALUES-sample frames with valid/ready on both sides.
// Optional synchronous frame abort input is enabled by ARGMAX_STREAM_ABORT_EN.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int NUM_VALUES        = 8,
  parameter int BITS_FOR_POSITION = 3,
  parameter int SIGNED_MODE       = 1,
  parameter int TIE_LAST          = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        in_value,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef ARGMAX_STREAM_ABORT_EN
  input  logic                         abort,
`endif
  output logic [BITS_FOR_POSITION-1:0] pos_max,
  output logic [DATA_WIDTH-1:0]        max_value,
  output logic                         busy
);

  localparam int POS_NEED = (NUM_VALUES <= 1) ? 1 : clog2(NUM_VALUES);
  localparam logic [BITS_FOR_POSITION-1:0] POS_ZERO = {BITS_FOR_POSITION{1'b0}};
  localparam logic [BITS_FOR_POSITION-1:0] POS_ONE  = BITS_FOR_POSITION'(1);
  localparam logic [BITS_FOR_POSITION-1:0] LAST_IDX = BITS_FOR_POSITION'(NUM_VALUES - 1);
  localparam logic [DATA_WIDTH-1:0]        DATA_ZERO = {DATA_WIDTH{1'b0}};

  generate
    if (NUM_VALUES < 1 || BITS_FOR_POSITION < POS_NEED) begin : g_bad_params
      $error("argmax_stream: NUM_VALUES must be >= 1 and fit in BITS_FOR_POSITION bits");
    end
  endgenerate

  state_t                         state_r, state_nx;
  logic [BITS_FOR_POSITION-1:0]   count_r, count_nx;
  logic [DATA_WIDTH-1:0]          run_max_r, run_max_nx;
  logic [BITS_FOR_POSITION-1:0]   run_pos_r, run_pos_nx;
  logic                           res_load_s;
  logic                           beat_s;
  logic                           gt_s, eq_s, take_s;
  logic                           abort_s;

`ifdef ARGMAX_STREAM_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign in_ready = (state_r != ST_HOLD);
  assign busy     = (state_r == ST_ACCUM);
  assign beat_s   = in_valid & in_ready;

  argmax_value_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIGNED_MODE(SIGNED_MODE)
  ) u_cmp (
    .a (in_value),
    .b (run_max_r),
    .gt(gt_s),
    .eq(eq_s)
  );

  // Equal samples only displace the holder when the later index is preferred.
  assign take_s = gt_s | ((TIE_LAST != 0) & eq_s);

  // Next-state, running-maximum update and result-load decision.
  always_comb begin
    state_nx   = state_r;
    count_nx   = count_r;
    run_max_nx = run_max_r;
    run_pos_nx = run_pos_r;
    res_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (beat_s) begin
          run_max_nx = in_value;
          run_pos_nx = POS_ZERO;
          if (NUM_VALUES == 1) begin
            state_nx   = ST_HOLD;
            count_nx   = POS_ZERO;
            res_load_s = 1'b1;
          end else begin
            state_nx = ST_ACCUM;
            count_nx = POS_ONE;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (abort_s) begin
          state_nx = ST_IDLE;
          count_nx = POS_ZERO;
        end else if (beat_s) begin
          if (take_s) begin
            run_max_nx = in_value;
            run_pos_nx = count_r;
          end else begin
            run_max_nx = run_max_r;
            run_pos_nx = run_pos_r;
          end
          if (count_r == LAST_IDX) begin
            state_nx   = ST_HOLD;
            count_nx   = POS_ZERO;
            res_load_s = 1'b1;
          end else begin
            state_nx = ST_ACCUM;
            count_nx = count_r + POS_ONE;
          end
        end else begin
          state_nx = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        count_nx = POS_ZERO;
      end
    endcase
  end

  // State, running maximum and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      count_r   <= POS_ZERO;
      run_max_r <= DATA_ZERO;
      run_pos_r <= POS_ZERO;
      out_valid <= 1'b0;
      max_value <= DATA_ZERO;
      pos_max   <= POS_ZERO;
    end else begin
      state_r   <= state_nx;
      count_r   <= count_nx;
      run_max_r <= run_max_nx;
      run_pos_r <= run_pos_nx;
      out_valid <= (state_nx == ST_HOLD);
      if (res_load_s) begin
        max_value <= run_max_nx;
        pos_max   <= run_pos_nx;
      end else begin
        max_value <= max_value;
        pos_max   <= pos_max;
      end
    end
  end

endmodule
